// File: rtl/timer_control_if.sv
// Front-panel bundle for the timer/stopwatch control stage.
// Raw operator inputs in, registered datapath controls out.
interface timer_control_if;
  logic btn_mode;
  logic btn_start;
  logic btn_clr;
  logic btn_ld;
  logic sw_dir;
  logic mode;
  logic state;
  logic clr;
  logic ld;
  logic dir;
  logic timer_clr;
  logic run_led;

  modport master (
    output btn_mode,
    output btn_start,
    output btn_clr,
    output btn_ld,
    output sw_dir,
    input  mode,
    input  state,
    input  clr,
    input  ld,
    input  dir,
    input  timer_clr,
    input  run_led
  );

  modport slave (
    input  btn_mode,
    input  btn_start,
    input  btn_clr,
    input  btn_ld,
    input  sw_dir,
    output mode,
    output state,
    output clr,
    output ld,
    output dir,
    output timer_clr,
    output run_led
  );
endinterface

// File: rtl/timer_control.sv
// Timer/stopwatch control: sync + debounce of panel inputs,
// run/pause FSM and registered datapath strobes.
module timer_control #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic            clk,
  input logic            rst,
  timer_control_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PAUSE,
    RUN,
    CLRP,
    LDP
  } fsm_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_MODE,
    EV_CLR,
    EV_LD,
    EV_START
  } ev_t;

  // bit order: 4 sw_dir, 3 ld, 2 clr, 1 start, 0 mode
  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    deb;
  logic [3:0]    deb_q;
  logic [CW-1:0] cnt [5];
  logic [3:0]    p;

  ev_t  ev;
  fsm_t fsm;
  fsm_t fsm_n;
  logic busy;

  logic mode_q;
  logic mode_n;
  logic state_q;
  logic state_d;
  logic clr_q;
  logic clr_d;
  logic ld_q;
  logic ld_d;
  logic tclr_q;
  logic tclr_d;
  logic dir_q;
  logic dir_d;
  logic run_q;
  logic run_d;

  assign raw = {
    bus.sw_dir,
    bus.btn_ld,
    bus.btn_clr,
    bus.btn_start,
    bus.btn_mode
  };

  // press = rising edge of a debounced button level
  assign p = deb[3:0] & ~deb_q;

  // Synchronise, then accept a level only after it holds
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb[3:0];
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Pick the single highest-priority press this cycle
  always_comb begin
    ev = EV_NONE;
    unique case (1'b1)
      p[0]:
        ev = EV_MODE;
      p[2] && !p[0]:
        ev = EV_CLR;
      p[3] && !p[2] && !p[0]:
        ev = EV_LD;
      p[1] && !p[3] && !p[2] && !p[0]:
        ev = EV_START;
      default:
        ev = EV_NONE;
    endcase
  end

  // CLRP/LDP are one-shot states that swallow events
  assign busy = (fsm == CLRP) || (fsm == LDP);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm     <= PAUSE;
      mode_q  <= 1'b0;
      state_q <= 1'b1;
      clr_q   <= 1'b0;
      ld_q    <= 1'b0;
      tclr_q  <= 1'b0;
      dir_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      fsm     <= fsm_n;
      mode_q  <= mode_n;
      state_q <= state_d;
      clr_q   <= clr_d;
      ld_q    <= ld_d;
      tclr_q  <= tclr_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
    end
  end

  // Next state: mode toggle wins, timer mode parks in PAUSE
  always_comb begin
    fsm_n  = fsm;
    mode_n = mode_q;
    if (busy) begin
      fsm_n = PAUSE;
    end else if (ev == EV_MODE) begin
      mode_n = ~mode_q;
      fsm_n  = PAUSE;
    end else if (!mode_q) begin
      fsm_n = PAUSE;
    end else begin
      unique case (fsm)
        PAUSE: begin
          unique case (ev)
            EV_START: fsm_n = RUN;
            EV_CLR:   fsm_n = CLRP;
            EV_LD:    fsm_n = LDP;
            default:  fsm_n = PAUSE;
          endcase
        end
        RUN: begin
          if (ev == EV_START) fsm_n = PAUSE;
        end
        default: fsm_n = PAUSE;
      endcase
    end
  end

  // Outputs derived from the state being entered
  always_comb begin
    state_d = (fsm_n == PAUSE);
    run_d   = (fsm_n == RUN);
    ld_d    = (fsm_n == LDP);
    clr_d   = (fsm_n == CLRP) ||
              (fsm == RUN && mode_q &&
               ev == EV_CLR);
    tclr_d  = !mode_q && !busy &&
              (ev == EV_CLR);
    dir_d   = deb[4];
  end

  assign bus.mode      = mode_q;
  assign bus.state     = state_q;
  assign bus.clr       = clr_q;
  assign bus.ld        = ld_q;
  assign bus.timer_clr = tclr_q;
  assign bus.dir       = dir_q;
  assign bus.run_led   = run_q;

endmodule

// File: tb/tb_timer_control.sv
// Directed bench for timer_control with a queue of
// expected output vectors popped as the DUT responds.
module tb_timer_control;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  timer_control_if bus();

  timer_control #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n_clr  = 0;
  int n_ld   = 0;
  int n_tclr = 0;
  int n_both = 0;

  // {run_led, dir, timer_clr, ld, clr, state, mode}
  logic [6:0] o;
  assign o = {bus.run_led, bus.dir, bus.timer_clr,
              bus.ld, bus.clr, bus.state, bus.mode};

  // Strobe cycle counters
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_clr  += int'(bus.clr);
      n_ld   += int'(bus.ld);
      n_tclr += int'(bus.timer_clr);
      if (int'(bus.clr) + int'(bus.ld) +
          int'(bus.timer_clr) > 1)
        n_both++;
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(int b, logic v);
    case (b)
      0: bus.btn_mode  = v;
      1: bus.btn_start = v;
      2: bus.btn_clr   = v;
      3: bus.btn_ld    = v;
      default: bus.sw_dir = v;
    endcase
  endtask

  task automatic push(string tag, logic [6:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_vec(string tag, logic [6:0] obs,
                           logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic pop_now();
    exp_t e;
    e = sb.pop_front();
    check_vec(e.tag, o, e.v);
  endtask

  task automatic pop_wait(int budget, output int lat);
    exp_t e;
    e = sb.pop_front();
    lat = 0;
    while (lat < budget && o !== e.v) begin
      @(negedge clk);
      lat++;
    end
    check_vec(e.tag, o, e.v);
  endtask

  task automatic press(int b, string tag,
                       logic [6:0] v, output int lat);
    drive(b, 1'b1);
    push(tag, v);
    pop_wait(15, lat);
  endtask

  task automatic rel(int b);
    drive(b, 1'b0);
    idle(12);
  endtask

  int lat;
  int c0;
  int l0;
  int t0;

  initial begin
    rst = 1'b0;
    bus.btn_mode  = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_clr   = 1'b0;
    bus.btn_ld    = 1'b0;
    bus.sw_dir    = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(20);
    push("reset", 7'b0000010);
    pop_now();

    drive(0, 1'b1);
    idle(2);
    drive(0, 1'b0);
    idle(15);
    push("glitch", 7'b0000010);
    pop_now();

    press(0, "mode_on", 7'b0000011, lat);
    check_int("mode_latency_ok",
              int'(lat >= 6 && lat <= 8), 1);
    idle(3);
    rel(0);

    press(1, "start_run", 7'b1000001, lat);
    rel(1);
    press(1, "start_pause", 7'b0000011, lat);
    rel(1);

    press(1, "hold_run", 7'b1000001, lat);
    idle(50);
    push("hold_once", 7'b1000001);
    pop_now();
    rel(1);
    push("hold_release", 7'b1000001);
    pop_now();
    press(1, "pause_again", 7'b0000011, lat);
    rel(1);

    c0 = n_clr;
    press(2, "pause_clr", 7'b0000101, lat);
    push("clr_end", 7'b0000011);
    idle(1);
    pop_now();
    rel(2);
    check_int("clr_count", n_clr - c0, 1);

    l0 = n_ld;
    press(3, "pause_ld", 7'b0001001, lat);
    push("ld_end", 7'b0000011);
    idle(1);
    pop_now();
    rel(3);
    check_int("ld_count", n_ld - l0, 1);

    press(1, "run2", 7'b1000001, lat);
    rel(1);
    l0 = n_ld;
    drive(3, 1'b1);
    idle(15);
    rel(3);
    check_int("ld_in_run", n_ld - l0, 0);
    push("run_after_ld", 7'b1000001);
    pop_now();

    press(0, "mode_off", 7'b0000010, lat);
    rel(0);

    c0 = n_clr;
    t0 = n_tclr;
    press(2, "timer_clr", 7'b0010010, lat);
    push("tclr_end", 7'b0000010);
    idle(1);
    pop_now();
    rel(2);
    check_int("tclr_count", n_tclr - t0, 1);
    check_int("no_clr_mode0", n_clr - c0, 0);

    c0 = n_clr;
    t0 = n_tclr;
    l0 = n_ld;
    drive(0, 1'b1);
    drive(2, 1'b1);
    push("mode_clr_same", 7'b0000011);
    pop_wait(15, lat);
    idle(5);
    drive(0, 1'b0);
    rel(2);
    check_int("same_edge_strobes",
              (n_clr - c0) + (n_tclr - t0) + (n_ld - l0), 0);

    press(1, "run3", 7'b1000001, lat);
    rel(1);
    drive(4, 1'b1);
    push("dir_down", 7'b1100001);
    pop_wait(15, lat);

    press(2, "run_clr", 7'b1100101, lat);
    push("run_clr_end", 7'b1100001);
    idle(1);
    pop_now();
    rel(2);

    press(2, "run_clr2", 7'b1100101, lat);
    rst = 1'b0;
    push("rst_mid", 7'b0000010);
    idle(1);
    pop_now();
    drive(2, 1'b0);
    idle(2);
    rst = 1'b1;
    push("dir_after_rst", 7'b0100010);
    pop_wait(20, lat);

    check_int("strobe_overlap", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_control.md
Name: timer_control

Overview:
Upstream control stage for the timer/stopwatch datapath. It synchronises and debounces the raw front-panel buttons and direction switch, then runs the stopwatch run/pause state machine. It produces the datapath control signals mode, state, clr, ld, dir and timer_clr. Every output is registered and feeds the datapath directly.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles required before an input level is accepted (10 ms at 100 MHz); minimum 2.

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
btn_mode  input  1  raw button, asynchronous, active-high; toggles timer/stopwatch mode
btn_start  input  1  raw button; stopwatch start/pause toggle
btn_clr  input  1  raw button; clear (timer or stopwatch, depending on mode)
btn_ld  input  1  raw button; stopwatch preset load
sw_dir  input  1  raw slide switch; stopwatch count direction
mode  output  1  0 = timer, 1 = stopwatch
state  output  1  1 = datapath holds, 0 = datapath counts / accepts clr, ld
clr  output  1  stopwatch clear strobe
ld  output  1  stopwatch load strobe
dir  output  1  debounced sw_dir (0 = up, 1 = down)
timer_clr  output  1  timer clear strobe
run_led  output  1  1 while the FSM is in RUN

Behaviour:
- Reset (rst=0 at a clk edge):
  - mode=0, state=1, clr=0, ld=0, timer_clr=0, dir=0, run_led=0.
  - FSM=PAUSE.
  - All synchroniser flops, debounced levels and debounce counters = 0.
- Input conditioning, identical for each of the 5 inputs:
  - 2-flop synchroniser.
  - Per-input debounce counter: cleared when the synced level equals the debounced level; otherwise increments. On reaching DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press event: one-cycle internal pulse p_x on a 0->1 edge of a debounced button level. Release generates no event.
- Latency: raw edge to p_x = 2 + DEBOUNCE_CYCLES cycles (±1). Outputs respond on the clk edge after p_x.
- dir = debounced sw_dir, updated in every mode and state.
- Priority within one cycle: p_mode > p_clr > p_ld > p_start. Only the highest-priority event acts; lower-priority events in the same cycle are discarded.
- p_mode:
  - mode toggles; FSM forced to PAUSE.
  - Next cycle: state=1, clr=ld=timer_clr=0.
- Mode 0 (timer):
  - FSM held in PAUSE; state=1.
  - p_clr -> timer_clr=1 for exactly one cycle.
  - p_ld and p_start ignored.
- Mode 1 (stopwatch). FSM states (state / run_led):
  - PAUSE (1/0):
    - p_start -> RUN.
    - p_clr -> CLRP.
    - p_ld -> LDP.
  - RUN (0/1):
    - p_start -> PAUSE.
    - p_clr -> clr=1 for one cycle, FSM stays in RUN.
    - p_ld ignored.
  - CLRP (0/0): one cycle, clr=1 and state=0 (the datapath acts on clr only while state=0), then -> PAUSE.
  - LDP (0/0): one cycle, ld=1 and state=0, then -> PAUSE.
- While in CLRP or LDP, any event is discarded.
- clr, ld and timer_clr are never asserted for more than one consecutive cycle, and never together.
- A held button produces exactly one event.
- Reset asserted mid-strobe or mid-debounce: all outputs take their reset values on that edge, and any pending press is lost.

Test Plan:
1. DEBOUNCE_CYCLES=4; release reset, idle 20 cycles -> mode=0, state=1, clr=ld=timer_clr=0, dir=0.
2. Press btn_mode for 10 cycles -> mode=1 about 7 cycles after the edge. Raw pulse of 2 cycles on btn_mode -> no change.
3. Mode 1, PAUSE: press btn_start -> state=0, run_led=1. Press again -> state=1, run_led=0. Hold btn_start 50 cycles -> only one toggle.
4. Mode 1, PAUSE: press btn_clr -> exactly one cycle with clr=1 and state=0, then state=1. Repeat with btn_ld -> ld=1 for one cycle with state=0. btn_ld during RUN -> ld stays 0.
5. Mode 0: press btn_clr -> timer_clr=1 for one cycle, clr stays 0. Press btn_mode and btn_clr on the same edge -> mode toggles, no strobes.
6. Mode 1, RUN: toggle sw_dir -> dir follows after debounce. Drive rst=0 during a clr strobe -> next cycle clr=0, mode=0, state=1.
